// File: rtl/flash_wb_ctrl.sv
// Wishbone slave read controller for parallel NOR flash: address/control registers,
// programmable access wait count, optional address auto-increment and abort on strobe drop.
module flash_wb_ctrl #(
    parameter int ADDR_W   = 22,
    parameter int WAIT_W   = 4,
    parameter int WAIT_RST = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    input  logic              wb_we_i,
    input  logic [1:0]        wb_adr_i,
    input  logic [1:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] flash_addr_,
    input  logic [15:0]       flash_data_,
    output logic              flash_we_n_,
    output logic              flash_oe_n_,
    output logic              flash_ce_n_,
    output logic              flash_rst_n_
);
    localparam int HI_W = ADDR_W - 16;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  cnt_reg, cnt_next;
    logic [WAIT_W-1:0]  wait_reg, wait_next;
    logic               autoinc_reg, autoinc_next;
    logic               data_rd_reg, data_rd_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [15:0]        dat_reg, dat_next;
    logic               ack_reg, ack_next;
    logic               strobe_n_reg, strobe_n_next;
    logic               rst_n_reg;
    logic               op;
    logic               data_read;
    logic [15:0]        hi_val, ctrl_val;

    assign op        = wb_stb_i & wb_cyc_i;
    assign data_read = (wb_adr_i == 2'd2) && !wb_we_i;

    always_comb begin
        hi_val = '0;
        hi_val[HI_W-1:0] = addr_reg[ADDR_W-1:16];
        ctrl_val = '0;
        ctrl_val[WAIT_W-1:0] = wait_reg;
        ctrl_val[8]  = autoinc_reg;
        ctrl_val[15] = (state_reg != IDLE);
    end

    // State register together with the registered datapath and pad outputs
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            wait_reg     <= WAIT_W'(WAIT_RST);
            autoinc_reg  <= 1'b0;
            data_rd_reg  <= 1'b0;
            addr_reg     <= '0;
            dat_reg      <= '0;
            ack_reg      <= 1'b0;
            strobe_n_reg <= 1'b1;
            rst_n_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            wait_reg     <= wait_next;
            autoinc_reg  <= autoinc_next;
            data_rd_reg  <= data_rd_next;
            addr_reg     <= addr_next;
            dat_reg      <= dat_next;
            ack_reg      <= ack_next;
            strobe_n_reg <= strobe_n_next;
            rst_n_reg    <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (op) state_next = data_read ? ACCESS : ACK;
            ACCESS:  if (!op) state_next = IDLE;
                     else if (cnt_reg == '0) state_next = ACK;
            ACK:     if (ack_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/datapath logic; ACK stays until the registered ack has been shown once
    always_comb begin
        cnt_next      = cnt_reg;
        wait_next     = wait_reg;
        autoinc_next  = autoinc_reg;
        data_rd_next  = data_rd_reg;
        addr_next     = addr_reg;
        dat_next      = dat_reg;
        ack_next      = 1'b0;
        strobe_n_next = strobe_n_reg;
        case (state_reg)
            IDLE: begin
                if (op) begin
                    data_rd_next = data_read;
                    if (data_read) begin
                        cnt_next      = wait_reg;
                        strobe_n_next = 1'b0;
                    end else if (wb_we_i) begin
                        case (wb_adr_i)
                            2'd0: begin
                                if (wb_sel_i[0]) addr_next[7:0]  = wb_dat_i[7:0];
                                if (wb_sel_i[1]) addr_next[15:8] = wb_dat_i[15:8];
                            end
                            2'd1: begin
                                for (int i = 0; i < HI_W; i++)
                                    if (wb_sel_i[i/8]) addr_next[16+i] = wb_dat_i[i];
                            end
                            2'd3: begin
                                if (wb_sel_i[0]) wait_next    = wb_dat_i[WAIT_W-1:0];
                                if (wb_sel_i[1]) autoinc_next = wb_dat_i[8];
                            end
                            default: ;
                        endcase
                    end else begin
                        case (wb_adr_i)
                            2'd0:    dat_next = addr_reg[15:0];
                            2'd1:    dat_next = hi_val;
                            default: dat_next = ctrl_val;
                        endcase
                    end
                end
            end
            ACCESS: begin
                if (!op) begin
                    strobe_n_next = 1'b1;
                end else if (cnt_reg == '0) begin
                    dat_next      = flash_data_;
                    strobe_n_next = 1'b1;
                    ack_next      = 1'b1;
                end else begin
                    cnt_next = cnt_reg - WAIT_W'(1);
                end
            end
            ACK: begin
                if (!ack_reg) ack_next = 1'b1;
                else if (data_rd_reg && autoinc_reg) addr_next = addr_reg + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    assign wb_dat_o     = dat_reg;
    assign wb_ack_o     = ack_reg;
    assign flash_addr_  = addr_reg;
    assign flash_we_n_  = 1'b1;
    assign flash_oe_n_  = strobe_n_reg;
    assign flash_ce_n_  = strobe_n_reg;
    assign flash_rst_n_ = rst_n_reg;
endmodule

// File: tb/tb_flash_wb_ctrl.sv
// Directed self-checking bench for flash_wb_ctrl with a combinational flash model.
module tb_flash_wb_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dat_i, dat_o;
    logic        we, stb, cyc, ack;
    logic [1:0]  adr, sel;
    logic [21:0] faddr;
    logic [15:0] fdata;
    logic        we_n, oe_n, ce_n, frst_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Flash model: one marker word, otherwise a pattern derived from the address
    assign fdata = (faddr == 22'h2A1234) ? 16'hBEEF : (faddr[15:0] ^ 16'h5A5A);

    flash_wb_ctrl #(.ADDR_W(22), .WAIT_W(4), .WAIT_RST(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_we_i(we), .wb_adr_i(adr), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_ack_o(ack), .flash_addr_(faddr), .flash_data_(fdata), .flash_we_n_(we_n),
        .flash_oe_n_(oe_n), .flash_ce_n_(ce_n), .flash_rst_n_(frst_n)
    );

    // Bus driver: lat = edges after E0 at which ack was seen (-1 on timeout)
    task automatic bus(input logic w, input logic [1:0] a, input logic [15:0] d,
                       input logic [1:0] s, output logic [15:0] rdata,
                       output int lat, output int acks, output int strobe_low, output int we_low);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        lat = -1; acks = 0; strobe_low = 0; we_low = 0; rdata = 16'h0;
        @(posedge clk);
        for (int n = 0; n < 40; n++) begin
            #1;
            if (!ce_n && !oe_n) strobe_low++;
            if (!we_n) we_low++;
            if (ack) begin
                acks++;
                if (lat < 0) begin
                    lat = n; rdata = dat_o;
                    stb = 1'b0; cyc = 1'b0; we = 1'b0;
                end
            end
            if (lat >= 0 && n >= lat + 3) break;
            @(posedge clk);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        $display("bus we=%0b adr=%0d din=%h sel=%b -> dout=%h lat=%0d acks=%0d strobe_low=%0d",
                 w, a, d, s, rdata, lat, acks, strobe_low);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        logic [15:0] r; int l, k, c, wl;
        bus(1'b1, a, d, 2'b11, r, l, k, c, wl);
    endtask

    task automatic test_reset();
        logic [15:0] r; int l, k, c, wl;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (frst_n !== 1'b0) begin errors++; $display("FAIL rst_flash_rst_n: got %b expected 0", frst_n); end
        checks++; if ({ack, ce_n, oe_n, we_n} !== 4'b0111) begin errors++; $display("FAIL rst_pins: got ack/ce/oe/we=%b expected 0111", {ack, ce_n, oe_n, we_n}); end
        checks++; if (dat_o !== 16'h0 || faddr !== 22'h0) begin errors++; $display("FAIL rst_regs: got dat=%h addr=%h expected 0/0", dat_o, faddr); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (frst_n !== 1'b1) begin errors++; $display("FAIL rst_release: got flash_rst_n=%b expected 1", frst_n); end
        bus(1'b0, 2'd3, 16'h0, 2'b11, r, l, k, c, wl);
        checks++; if (l !== 1) begin errors++; $display("FAIL ctrl_rd_lat: got %0d expected 1", l); end
        checks++; if (r !== 16'h0004) begin errors++; $display("FAIL ctrl_rd_data: got %h expected 0004", r); end
    endtask

    task automatic test_data_read();
        logic [15:0] r; int l, k, c, wl;
        wr(2'd0, 16'h1234);
        wr(2'd1, 16'h002A);
        checks++; if (faddr !== 22'h2A1234) begin errors++; $display("FAIL addr_set: got %h expected 2a1234", faddr); end
        bus(1'b0, 2'd2, 16'h0, 2'b11, r, l, k, c, wl);
        checks++; if (l !== 5) begin errors++; $display("FAIL rd_lat: got %0d expected 5", l); end
        checks++; if (c !== 5) begin errors++; $display("FAIL rd_strobe_len: got %0d expected 5", c); end
        checks++; if (k !== 1) begin errors++; $display("FAIL rd_ack_count: got %0d expected 1", k); end
        checks++; if (r !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h expected beef", r); end
        checks++; if (faddr !== 22'h2A1234) begin errors++; $display("FAIL rd_addr_kept: got %h expected 2a1234", faddr); end
        bus(1'b0, 2'd1, 16'h0, 2'b11, r, l, k, c, wl);
        checks++; if (r !== 16'h002A) begin errors++; $display("FAIL addr_hi_rd: got %h expected 002a", r); end
    endtask

    task automatic test_autoinc_wrap();
        logic [15:0] r; int l, k, c, wl;
        logic [21:0] exp_addr [3];
        logic [15:0] exp_data [3];
        exp_addr[0] = 22'h3FFFFE; exp_data[0] = 16'hA5A4;
        exp_addr[1] = 22'h3FFFFF; exp_data[1] = 16'hA5A5;
        exp_addr[2] = 22'h000000; exp_data[2] = 16'h5A5A;
        wr(2'd3, 16'h0100);
        wr(2'd0, 16'hFFFE);
        wr(2'd1, 16'h003F);
        for (int i = 0; i < 3; i++) begin
            checks++; if (faddr !== exp_addr[i]) begin errors++; $display("FAIL inc_addr%0d: got %h expected %h", i, faddr, exp_addr[i]); end
            bus(1'b0, 2'd2, 16'h0, 2'b11, r, l, k, c, wl);
            checks++; if (r !== exp_data[i]) begin errors++; $display("FAIL inc_data%0d: got %h expected %h", i, r, exp_data[i]); end
            checks++; if (l !== 1 || c !== 1) begin errors++; $display("FAIL inc_timing%0d: got lat=%0d strobe=%0d expected 1/1", i, l, c); end
        end
        checks++; if (faddr !== 22'h000001) begin errors++; $display("FAIL inc_final: got %h expected 000001", faddr); end
    endtask

    task automatic test_abort();
        logic [15:0] r; int l, k, c, wl;
        int acks = 0;
        wr(2'd3, 16'h0104);
        wr(2'd0, 16'h0010);
        wr(2'd1, 16'h0000);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 2'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        checks++; if (ce_n !== 1'b1 || oe_n !== 1'b1) begin errors++; $display("FAIL abort_strobe: got ce/oe=%b%b expected 11", ce_n, oe_n); end
        for (int n = 0; n < 6; n++) begin
            if (ack) acks++;
            @(posedge clk); #1;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL abort_ack: got %0d acks expected 0", acks); end
        checks++; if (faddr !== 22'h000010) begin errors++; $display("FAIL abort_addr: got %h expected 000010", faddr); end
        bus(1'b0, 2'd2, 16'h0, 2'b11, r, l, k, c, wl);
        checks++; if (r !== 16'h5A4A || l !== 5) begin errors++; $display("FAIL after_abort_rd: got data=%h lat=%0d expected 5a4a/5", r, l); end
        checks++; if (faddr !== 22'h000011) begin errors++; $display("FAIL after_abort_inc: got %h expected 000011", faddr); end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] r; int l, k, c, wl;
        wr(2'd0, 16'h0123);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 2'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        checks++; if ({ack, ce_n, oe_n} !== 3'b011) begin errors++; $display("FAIL midrst_pins: got ack/ce/oe=%b expected 011", {ack, ce_n, oe_n}); end
        checks++; if (faddr !== 22'h0) begin errors++; $display("FAIL midrst_addr: got %h expected 000000", faddr); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus(1'b0, 2'd3, 16'h0, 2'b11, r, l, k, c, wl);
        checks++; if (r !== 16'h0004) begin errors++; $display("FAIL midrst_ctrl: got %h expected 0004", r); end
    endtask

    task automatic test_byte_lanes();
        logic [15:0] r; int l, k, c, wl;
        bus(1'b1, 2'd3, 16'h0107, 2'b10, r, l, k, c, wl);
        bus(1'b0, 2'd3, 16'h0, 2'b11, r, l, k, c, wl);
        checks++; if (r !== 16'h0104) begin errors++; $display("FAIL sel_ctrl: got %h expected 0104", r); end
        bus(1'b1, 2'd2, 16'hDEAD, 2'b11, r, l, k, c, wl);
        checks++; if (l !== 1 || k !== 1) begin errors++; $display("FAIL data_wr_ack: got lat=%0d acks=%0d expected 1/1", l, k); end
        checks++; if (wl !== 0 || c !== 0) begin errors++; $display("FAIL data_wr_pins: got we_low=%0d strobe_low=%0d expected 0/0", wl, c); end
    endtask

    initial begin
        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        adr = 2'd0; sel = 2'b11; dat_i = 16'h0;
        test_reset();
        test_data_read();
        test_autoinc_wrap();
        test_abort();
        test_reset_mid_access();
        test_byte_lanes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
